// File: rtl/lsq_mem_arbiter.sv
// Single-port data memory arbiter between LSQ load issue and committed-store drain.
// Optional last-store forwarding is built when STORE_FWD_EN is defined.
module lsq_mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ld_req_valid,
  output logic             ld_req_ready,
  input  logic [31:0]      ld_req_addr,
  input  logic [TAG_W-1:0] ld_req_tag,
  input  logic             st_req_valid,
  output logic             st_req_ready,
  input  logic [31:0]      st_req_addr,
  input  logic [31:0]      st_req_data,
  input  logic             flush,
  output logic             ld_resp_valid,
  output logic [TAG_W-1:0] ld_resp_tag,
  output logic [31:0]      ld_resp_data,
  output logic             mem_en,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             busy
);

  localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_CAP = SW'(STARVE_MAX);
  localparam logic [2:0]    LAT_INIT   = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STORE
  } state_t;

  state_t           state;
  logic [2:0]       lat_cnt;
  logic [SW-1:0]    starve_cnt;
  logic             flush_pend;
  logic [TAG_W-1:0] ld_tag_q;
  logic             force_st;
  logic             idle;
  logic             fwd_hit;

  // Byte offsets are dropped: the memory is word-addressed.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{ld_req_addr[1:0], st_req_addr[1:0]};

`ifdef STORE_FWD_EN
  logic             fwd_valid;
  logic [29:0]      fwd_addr;
  logic [31:0]      fwd_data;
  logic             fwd_pend;
  logic [TAG_W-1:0] fwd_tag;
  logic [31:0]      fwd_rdata;

  always_comb begin
    fwd_hit = fwd_valid && (fwd_addr == ld_req_addr[31:2]);
  end
`else
  always_comb begin
    fwd_hit = 1'b0;
  end
`endif

  always_comb begin
    idle         = (state == IDLE);
    force_st     = st_req_valid && (starve_cnt >= STARVE_CAP);
    st_req_ready = idle && st_req_valid && (force_st || !ld_req_valid);
    ld_req_ready = idle && ld_req_valid && !force_st && !flush;
    busy         = !idle;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
      flush_pend    <= 1'b0;
      ld_tag_q      <= '0;
      ld_resp_valid <= 1'b0;
      ld_resp_tag   <= '0;
      ld_resp_data  <= '0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
`ifdef STORE_FWD_EN
      fwd_valid     <= 1'b0;
      fwd_addr      <= '0;
      fwd_data      <= '0;
      fwd_pend      <= 1'b0;
      fwd_tag       <= '0;
      fwd_rdata     <= '0;
`endif
    end else begin
      ld_resp_valid <= 1'b0;
`ifdef STORE_FWD_EN
      // A forwarded load answers one cycle after accept unless squashed meanwhile.
      fwd_pend <= 1'b0;
      if (fwd_pend && !flush) begin
        ld_resp_valid <= 1'b1;
        ld_resp_tag   <= fwd_tag;
        ld_resp_data  <= fwd_rdata;
      end
`endif
      case (state)
        IDLE: begin
          if (st_req_ready) begin
            state      <= STORE;
            mem_en     <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= {st_req_addr[31:2], 2'b00};
            mem_wdata  <= st_req_data;
            starve_cnt <= '0;
`ifdef STORE_FWD_EN
            fwd_valid  <= 1'b1;
            fwd_addr   <= st_req_addr[31:2];
            fwd_data   <= st_req_data;
`endif
          end else if (ld_req_ready) begin
            if (!st_req_valid) begin
              starve_cnt <= '0;
            end else if (starve_cnt < STARVE_CAP) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
            if (fwd_hit) begin
`ifdef STORE_FWD_EN
              fwd_pend  <= 1'b1;
              fwd_tag   <= ld_req_tag;
              fwd_rdata <= fwd_data;
`endif
            end else begin
              state    <= LOAD;
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {ld_req_addr[31:2], 2'b00};
              ld_tag_q <= ld_req_tag;
              lat_cnt  <= LAT_INIT;
            end
          end
        end

        LOAD: begin
          mem_en <= 1'b0;
          if (flush) begin
            flush_pend <= 1'b1;
          end
          // The memory stays occupied for the full latency even when squashed.
          if (lat_cnt == 3'd0) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            if (!(flush_pend || flush)) begin
              ld_resp_valid <= 1'b1;
              ld_resp_tag   <= ld_tag_q;
              ld_resp_data  <= mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        STORE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter: readiness table, transaction table, and
// hand-written starvation, flush, reset and forwarding sequences.
module tb_lsq_mem_arbiter;

  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned TAG_W      = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             ld_req_valid = 1'b0;
  logic             ld_req_ready;
  logic [31:0]      ld_req_addr = '0;
  logic [TAG_W-1:0] ld_req_tag = '0;
  logic             st_req_valid = 1'b0;
  logic             st_req_ready;
  logic [31:0]      st_req_addr = '0;
  logic [31:0]      st_req_data = '0;
  logic             flush = 1'b0;
  logic             ld_resp_valid;
  logic [TAG_W-1:0] ld_resp_tag;
  logic [31:0]      ld_resp_data;
  logic             mem_en;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [31:0]      mem_rdata;
  logic             busy;

  always #5 clk = ~clk;

  lsq_mem_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX),
    .TAG_W     (TAG_W)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ld_req_valid (ld_req_valid),
    .ld_req_ready (ld_req_ready),
    .ld_req_addr  (ld_req_addr),
    .ld_req_tag   (ld_req_tag),
    .st_req_valid (st_req_valid),
    .st_req_ready (st_req_ready),
    .st_req_addr  (st_req_addr),
    .st_req_data  (st_req_data),
    .flush        (flush),
    .ld_resp_valid(ld_resp_valid),
    .ld_resp_tag  (ld_resp_tag),
    .ld_resp_data (ld_resp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  // Memory model: read data valid MEM_LAT cycles after the read-enable cycle.
  logic [31:0] mem [0:63];
  logic [31:0] rd_a [0:MEM_LAT-1];
  logic        rd_v [0:MEM_LAT-1];
  logic        init_mem = 1'b1;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[4] <= 32'hDEAD_BEEF;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    rd_v[0] <= mem_en && !mem_we;
    rd_a[0] <= mem_addr;
    for (int i = 1; i < MEM_LAT; i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
  end

  assign mem_rdata = rd_v[MEM_LAT-1] ? mem[rd_a[MEM_LAT-1][7:2]] : 32'hBAD0_BAD0;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [TAG_W-1:0] tag,
                         input logic [31:0] exp_data);
    int lat;
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = addr; ld_req_tag = tag;
    #1 chk("ld_ready", 32'(ld_req_ready), 32'd1);
    @(negedge clk);
    ld_req_valid = 1'b0;
    chk("ld_mem_en", 32'(mem_en), 32'd1);
    chk("ld_mem_we", 32'(mem_we), 32'd0);
    chk("ld_mem_addr", mem_addr, {addr[31:2], 2'b00});
    chk("ld_busy", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) chk("ld_mem_en_one_cycle", 32'(mem_en), 32'd0);
      if (ld_resp_valid) begin
        lat = k;
        break;
      end
    end
    chk("ld_latency", 32'(lat), 32'(1 + MEM_LAT));
    chk("ld_resp_tag", 32'(ld_resp_tag), 32'(tag));
    chk("ld_resp_data", ld_resp_data, exp_data);
    @(negedge clk);
    chk("ld_resp_pulse", 32'(ld_resp_valid), 32'd0);
    chk("ld_idle_after", 32'(busy), 32'd0);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    st_req_valid = 1'b1; st_req_addr = addr; st_req_data = data;
    #1 chk("st_ready", 32'(st_req_ready), 32'd1);
    @(negedge clk);
    st_req_valid = 1'b0;
    chk("st_mem_en", 32'(mem_en), 32'd1);
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_mem_addr", mem_addr, {addr[31:2], 2'b00});
    chk("st_mem_wdata", mem_wdata, data);
    chk("st_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("st_busy_one_cycle", 32'(busy), 32'd0);
    chk("st_mem_en_one_cycle", 32'(mem_en), 32'd0);
  endtask

  typedef struct {
    logic ld;
    logic st;
    logic fl;
    logic exp_ld_ready;
    logic exp_st_ready;
  } arb_vec_t;

  typedef struct {
    logic             is_st;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } txn_t;

  arb_vec_t arb_tab [7];
  txn_t     txn_tab [7];

  initial begin
    int nl;
    logic got_st;
    logic resp_seen;

    arb_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    arb_tab[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    arb_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    arb_tab[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    arb_tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    arb_tab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    arb_tab[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    txn_tab[0] = '{1'b0, 32'h0000_0013, 32'hDEAD_BEEF, 4'd5};
    txn_tab[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'd0};
    txn_tab[2] = '{1'b1, 32'h0000_003F, 32'hA5A5_5A5A, 4'd0};
    txn_tab[3] = '{1'b1, 32'h0000_0030, 32'h3030_3030, 4'd0};
    txn_tab[4] = '{1'b0, 32'h0000_0023, 32'h1234_5678, 4'd9};
    txn_tab[5] = '{1'b0, 32'h0000_003C, 32'hA5A5_5A5A, 4'd15};
    txn_tab[6] = '{1'b0, 32'h0000_0008, 32'h1000_0002, 4'd0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_resp_valid", 32'(ld_resp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    init_mem = 1'b0;
    @(negedge clk);

    // Combinational readiness in IDLE with a cleared starvation counter
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      ld_req_valid = arb_tab[i].ld; st_req_valid = arb_tab[i].st; flush = arb_tab[i].fl;
      ld_req_addr = 32'h50; st_req_addr = 32'h60;
      #1;
      chk($sformatf("arb%0d_ld_ready", i), 32'(ld_req_ready), 32'(arb_tab[i].exp_ld_ready));
      chk($sformatf("arb%0d_st_ready", i), 32'(st_req_ready), 32'(arb_tab[i].exp_st_ready));
      ld_req_valid = 1'b0; st_req_valid = 1'b0; flush = 1'b0;
    end

    for (int i = 0; i < 7; i++) begin
      if (txn_tab[i].is_st) do_store(txn_tab[i].addr, txn_tab[i].data);
      else do_load(txn_tab[i].addr, txn_tab[i].tag, txn_tab[i].data);
    end

    // Starvation: both requesters held valid
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h50; ld_req_tag = 4'd7;
    st_req_valid = 1'b1; st_req_addr = 32'h60; st_req_data = 32'h6060_6060;
    nl = 0;
    got_st = 1'b0;
    for (int c = 0; c < 60 && !got_st; c++) begin
      #1;
      if (st_req_ready) got_st = 1'b1;
      else if (ld_req_ready) nl++;
      @(negedge clk);
    end
    ld_req_valid = 1'b0; st_req_valid = 1'b0;
    chk("starve_loads_before_store", 32'(nl), 32'(STARVE_MAX));
    chk("starve_store_granted", 32'(got_st), 32'd1);
    chk("starve_store_wdata", mem_wdata, 32'h6060_6060);
    @(negedge clk);
    ld_req_valid = 1'b1; st_req_valid = 1'b1;
    #1;
    chk("starve_cleared_ld_ready", 32'(ld_req_ready), 32'd1);
    chk("starve_cleared_st_ready", 32'(st_req_ready), 32'd0);
    ld_req_valid = 1'b0; st_req_valid = 1'b0;

    // Flush one cycle after a load grant
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h50; ld_req_tag = 4'd2;
    #1 chk("flush_ld_ready", 32'(ld_req_ready), 32'd1);
    @(negedge clk);
    ld_req_valid = 1'b0;
    flush = 1'b1;
    resp_seen = ld_resp_valid;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      flush = 1'b0;
      if (ld_resp_valid) resp_seen = 1'b1;
      if (k <= MEM_LAT) chk("flush_busy_held", 32'(busy), 32'd1);
      if (k == MEM_LAT + 1) chk("flush_busy_drop", 32'(busy), 32'd0);
    end
    chk("flush_no_resp", 32'(resp_seen), 32'd0);
    do_load(32'h0000_0014, 4'hA, 32'h1000_0005);

    // Reset in the middle of a load
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h14; ld_req_tag = 4'd6;
    @(negedge clk);
    ld_req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("rstload_mem_en", 32'(mem_en), 32'd0);
    chk("rstload_mem_we", 32'(mem_we), 32'd0);
    chk("rstload_mem_addr", mem_addr, 32'd0);
    chk("rstload_mem_wdata", mem_wdata, 32'd0);
    chk("rstload_resp_valid", 32'(ld_resp_valid), 32'd0);
    chk("rstload_resp_tag", 32'(ld_resp_tag), 32'd0);
    chk("rstload_resp_data", ld_resp_data, 32'd0);
    chk("rstload_busy", 32'(busy), 32'd0);
    rstn = 1'b1;
    resp_seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ld_resp_valid) resp_seen = 1'b1;
    end
    chk("rstload_no_stale_resp", 32'(resp_seen), 32'd0);

    // Load of a just-stored word
    do_store(32'h0000_0040, 32'hCAFE_0001);
`ifdef STORE_FWD_EN
    @(negedge clk);
    ld_req_valid = 1'b1; ld_req_addr = 32'h42; ld_req_tag = 4'd3;
    #1 chk("fwd_ld_ready", 32'(ld_req_ready), 32'd1);
    @(negedge clk);
    ld_req_valid = 1'b0;
    chk("fwd_mem_en", 32'(mem_en), 32'd0);
    chk("fwd_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("fwd_resp_valid", 32'(ld_resp_valid), 32'd1);
    chk("fwd_resp_tag", 32'(ld_resp_tag), 32'd3);
    chk("fwd_resp_data", ld_resp_data, 32'hCAFE_0001);
    chk("fwd_mem_en_idle", 32'(mem_en), 32'd0);
    @(negedge clk);
    chk("fwd_resp_pulse", 32'(ld_resp_valid), 32'd0);
    ld_req_valid = 1'b1; ld_req_addr = 32'h40; ld_req_tag = 4'd8;
    @(negedge clk);
    ld_req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fwd_flush_no_resp", 32'(ld_resp_valid), 32'd0);
`else
    do_load(32'h0000_0042, 4'd3, 32'hCAFE_0001);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
